arbitro_rr: RTL and testbench
=============================

Name: arbitro_rr

Overview:
- Round-robin arbiter that moves words from the four input FIFOs (I0..I3) to the four output FIFOs (O0..O3).
- Destination output is taken from each word's top 2 bits.
- Pops one input FIFO and pushes one output FIFO per cycle, but only while the link FSM reports active.
- Skips any word whose target output FIFO is almost-full, as set by the high threshold.
- Keeps per-output transfer counters readable through a request/valid port.

Parameters:
- DATA_W, 6, word width including the 2-bit destination field in [DATA_W-1:DATA_W-2]
- CNT_W, 8, width of each per-output transfer counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- active_in  in  1  link FSM in ACTIVE state; arbitration is allowed only when high
- emp_I  in  4  empty flags of input FIFOs, bit i = I_i
- data_I0..data_I3  in  DATA_W each  head word of input FIFO i (first-word-fall-through, valid when !emp_I[i])
- afull_O  in  4  almost-full flags of output FIFOs, bit j = O_j
- pop_I  out  4  one-hot pop strobe to input FIFOs
- push_O  out  4  one-hot push strobe to output FIFOs
- data_O  out  DATA_W  word driven to all output FIFOs, qualified by push_O
- cnt_req  in  1  counter read request
- cnt_sel  in  2  counter index for the read
- cnt_valid  out  1  read data valid
- cnt_out  out  CNT_W  selected counter value
- busy  out  1  high while state is SERVE

Behaviour:
- Reset (synchronous, sampled at posedge clk):
  - state = IDLE, rr_ptr = 0, all counters = 0.
  - cnt_valid = 0, cnt_out = 0, busy = 0.
  - pop_I = 0, push_O = 0, data_O = 0.
  - Reset has priority over every other input. Reset asserted mid-transfer kills any strobe in the reset cycle's successor; counters clear.
- FSM, registered, 2 states:
  - IDLE -> SERVE when active_in && (emp_I != 4'hF).
  - SERVE -> IDLE when !active_in || (emp_I == 4'hF).
  - Otherwise hold. busy = (state == SERVE), registered.
- Eligibility (combinational): input i is eligible when state == SERVE && !emp_I[i] && !afull_O[dest_i], where dest_i = data_Ii[DATA_W-1:DATA_W-2].
- Grant (combinational):
  - The first eligible input in order rr_ptr, rr_ptr+1, ... wrapping mod 4.
  - At most one grant per cycle.
  - No eligible input means no grant: pop_I = 0 and push_O = 0. This is not an error; the state does not change for this reason.
- Transfer, zero latency in the grant cycle:
  - pop_I[g] = 1 and push_O[dest_g] = 1.
  - data_O = data_Ig, the full word including the destination bits.
  - When there is no grant, data_O = 0.
- Pointer: on a grant g, rr_ptr <= (g+1) mod 4. With no grant, rr_ptr holds.
- Blocking: a word whose destination is almost-full is skipped. Other inputs are still served, so there is no head-of-line blocking across inputs.
- active_in falls while in SERVE: the cycle in which state is still SERVE may transfer. No transfer occurs once state is IDLE.
- Counters:
  - cnt_O[j] increments by 1 on each push_O[j] cycle.
  - Wraps from 2^CNT_W-1 to 0.
- Counter read:
  - cnt_req sampled at cycle N gives cnt_valid = 1 and cnt_out = cnt_O[cnt_sel] at N+1. The value shown is the pre-increment value at N.
  - cnt_valid is a 1-cycle pulse per request.
  - Back-to-back requests give back-to-back pulses.
  - When cnt_valid = 0, cnt_out holds its last value.
- Invariants:
  - popcount(pop_I) == popcount(push_O) <= 1.
  - Never pop an empty FIFO.
  - Never push to an almost-full FIFO.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE = 0, SERVE = 1.
  - N_PORTS = 4.
  - DEST_W = 2.
  - Function dest_of(word).
- Sub-module rr_picker: a 4-bit request vector plus a 2-bit pointer in, a one-hot grant plus a valid out, purely combinational. The top level instantiates it once. The FSM, counters and read port stay in the top level.

Test Plan:
- Reset, then hold reset while active_in = 1 and the inputs are non-empty -> pop_I = 0, push_O = 0, busy = 0, all counters read 0 after release.
- active_in = 1; I0 holds 3 words with dest 2, other inputs empty, afull_O = 0:
  - SERVE entered 1 cycle after active_in.
  - pop_I = 4'b0001 and push_O = 4'b0100 on 3 consecutive cycles.
  - cnt_sel = 2 read returns 3.
- All four inputs non-empty with distinct destinations, rr_ptr = 0 -> grants 0, 1, 2, 3, 0 on consecutive cycles.
- I1 head dest 3 with afull_O[3] = 1, I2 head dest 0 -> I1 skipped, I2 served each cycle. Deassert afull_O[3] -> I1 served on the next pointer turn.
- active_in drops mid-stream -> at most one transfer after the drop, then IDLE, busy = 0, no strobes while the inputs stay non-empty.
- 256 pushes to O1 -> cnt_O1 wraps to 0. A cnt_req in the same cycle as a push returns the pre-increment value at N+1.

Source files
------------

// File: rtl/arbitro_rr_pkg.sv
// rtl/arbitro_rr_pkg.sv - shared state encoding, sizes and destination helper for the round-robin arbiter
package arbitro_rr_pkg;

  localparam int N_PORTS = 4;
  localparam int DEST_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Destination is the top DEST_W bits of a data_w-wide word, passed zero-extended to 32 bits.
  function automatic logic [DEST_W-1:0] dest_of(input logic [31:0] word, input int data_w);
    return DEST_W'(word >> (data_w - DEST_W));
  endfunction

endpackage

// File: rtl/arbitro_rr_if.sv
// rtl/arbitro_rr_if.sv - input/output FIFO handshake bundle between the arbiter and its FIFOs
interface arbitro_rr_if #(
  parameter int DATA_W = 6
);

  logic [3:0]        emp_I;
  logic [DATA_W-1:0] data_I0;
  logic [DATA_W-1:0] data_I1;
  logic [DATA_W-1:0] data_I2;
  logic [DATA_W-1:0] data_I3;
  logic [3:0]        afull_O;
  logic [3:0]        pop_I;
  logic [3:0]        push_O;
  logic [DATA_W-1:0] data_O;

  modport master (
    input  emp_I, data_I0, data_I1, data_I2, data_I3, afull_O,
    output pop_I, push_O, data_O
  );

  modport slave (
    output emp_I, data_I0, data_I1, data_I2, data_I3, afull_O,
    input  pop_I, push_O, data_O
  );

endinterface

// File: rtl/arbitro_rr_rr_picker.sv
// rtl/arbitro_rr_rr_picker.sv - combinational round-robin picker: first request at or after ptr, wrapping
module rr_picker
  import arbitro_rr_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  logic [1:0]         ptr,
  output logic [N_PORTS-1:0] gnt,
  output logic               valid
);

  always_comb begin
    logic [1:0] idx;
    gnt   = '0;
    valid = 1'b0;
    idx   = ptr;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = ptr + 2'(k);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// rtl/arbitro_rr.sv - round-robin arbiter moving words from four input FIFOs to four output FIFOs
module arbitro_rr
  import arbitro_rr_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active_in,
  arbitro_rr_if.master     bus,
  input  logic             cnt_req,
  input  logic [1:0]       cnt_sel,
  output logic             cnt_valid,
  output logic [CNT_W-1:0] cnt_out,
  output logic             busy
);

  state_t             state;
  logic [1:0]         rr_ptr;
  logic [CNT_W-1:0]   cnt_O [N_PORTS];
  logic [DATA_W-1:0]  word  [N_PORTS];
  logic [DEST_W-1:0]  dest  [N_PORTS];
  logic [N_PORTS-1:0] elig;
  logic [N_PORTS-1:0] gnt;
  logic               gnt_valid;
  logic [1:0]         g_idx;
  logic [DEST_W-1:0]  g_dest;
  logic               all_empty;

  assign word[0]   = bus.data_I0;
  assign word[1]   = bus.data_I1;
  assign word[2]   = bus.data_I2;
  assign word[3]   = bus.data_I3;
  assign all_empty = &bus.emp_I;

  // A head word is only offered when its target FIFO can still take it.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      dest[i] = dest_of(32'(word[i]), DATA_W);
      elig[i] = (state == SERVE) && !bus.emp_I[i] && !bus.afull_O[dest[i]];
    end
  end

  rr_picker u_picker (
    .req   (elig),
    .ptr   (rr_ptr),
    .gnt   (gnt),
    .valid (gnt_valid)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (gnt[i]) g_idx = 2'(i);
    end
  end

  assign g_dest     = dest[g_idx];
  assign bus.pop_I  = gnt;
  assign bus.push_O = gnt_valid ? (N_PORTS'(1) << g_dest) : '0;
  assign bus.data_O = gnt_valid ? word[g_idx] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (active_in && !all_empty) begin
            state <= SERVE;
            busy  <= 1'b1;
          end
        end
        SERVE: begin
          if (!active_in || all_empty) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
      if (gnt_valid) rr_ptr <= g_idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < N_PORTS; j++) cnt_O[j] <= '0;
    end else begin
      for (int j = 0; j < N_PORTS; j++) begin
        if (bus.push_O[j]) cnt_O[j] <= cnt_O[j] + CNT_W'(1);
      end
    end
  end

  // The read samples the counter before this cycle's increment lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_valid <= 1'b0;
      cnt_out   <= '0;
    end else begin
      cnt_valid <= cnt_req;
      if (cnt_req) cnt_out <= cnt_O[cnt_sel];
    end
  end

endmodule

// File: tb/tb_arbitro_rr.sv
// tb/tb_arbitro_rr.sv - self-checking bench for arbitro_rr: vector table, directed sequences, random vs model
module tb_arbitro_rr;

  localparam int DW = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          active_in;
  logic          cnt_req;
  logic [1:0]    cnt_sel;
  logic          cnt_valid;
  logic [CW-1:0] cnt_out;
  logic          busy;

  arbitro_rr_if #(.DATA_W(DW)) bus ();

  arbitro_rr #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .active_in (active_in),
    .bus       (bus),
    .cnt_req   (cnt_req),
    .cnt_sel   (cnt_sel),
    .cnt_valid (cnt_valid),
    .cnt_out   (cnt_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    emp;
    logic [DW-1:0] d0, d1, d2, d3;
    logic [3:0]    afull;
    logic [3:0]    pop;
    logic [3:0]    push;
    logic [DW-1:0] dat;
  } vec_t;

  vec_t tv [12];

  int n_tests = 0;
  int n_fail  = 0;

  bit            m_serve;
  int            m_ptr;
  int            m_cnt [4];
  bit            m_cvalid;
  int            m_cout;
  bit            m_found;
  int            m_g;
  logic [3:0]    e_pop, e_push;
  logic [DW-1:0] e_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] in_word(input int i);
    case (i)
      0:       return bus.data_I0;
      1:       return bus.data_I1;
      2:       return bus.data_I2;
      default: return bus.data_I3;
    endcase
  endfunction

  function automatic int dst(input logic [DW-1:0] w);
    return int'(w[DW-1:DW-2]);
  endfunction

  // Reference: scan inputs from the pointer, first non-empty one whose target is not almost-full wins.
  task automatic model_comb();
    logic [DW-1:0] w;
    int i;
    e_pop = '0; e_push = '0; e_data = '0; m_found = 0; m_g = 0;
    if (m_serve) begin
      for (int k = 0; k < 4; k++) begin
        i = (m_ptr + k) % 4;
        w = in_word(i);
        if (!m_found && !bus.emp_I[i] && !bus.afull_O[dst(w)]) begin
          m_found = 1;
          m_g     = i;
        end
      end
    end
    if (m_found) begin
      e_data = in_word(m_g);
      e_pop[m_g] = 1'b1;
      e_push[dst(e_data)] = 1'b1;
    end
  endtask

  task automatic model_seq();
    if (reset) begin
      m_serve = 0; m_ptr = 0; m_cvalid = 0; m_cout = 0;
      for (int j = 0; j < 4; j++) m_cnt[j] = 0;
    end else begin
      m_cvalid = cnt_req;
      if (cnt_req) m_cout = m_cnt[cnt_sel];
      if (m_found) begin
        m_cnt[dst(e_data)] = (m_cnt[dst(e_data)] + 1) % (1 << CW);
        m_ptr = (m_g + 1) % 4;
      end
      m_serve = active_in && (bus.emp_I != 4'hF);
    end
  endtask

  task automatic tick();
    #1;
    model_comb();
    chk("pop_I",     32'(bus.pop_I),  32'(e_pop));
    chk("push_O",    32'(bus.push_O), 32'(e_push));
    chk("data_O",    32'(bus.data_O), 32'(e_data));
    chk("busy",      32'(busy),       32'(m_serve));
    chk("cnt_valid", 32'(cnt_valid),  32'(m_cvalid));
    chk("cnt_out",   32'(cnt_out),    32'(m_cout));
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic set_words(input logic [DW-1:0] a, b, c, d);
    bus.data_I0 = a; bus.data_I1 = b; bus.data_I2 = c; bus.data_I3 = d;
  endtask

  initial begin
    int xfers;
    tv[0]  = '{4'h0, 6'h05, 6'h1A, 6'h23, 6'h3C, 4'h0, 4'b0001, 4'b0001, 6'h05};
    tv[1]  = '{4'h0, 6'h05, 6'h1A, 6'h23, 6'h3C, 4'h0, 4'b0010, 4'b0010, 6'h1A};
    tv[2]  = '{4'h0, 6'h05, 6'h1A, 6'h23, 6'h3C, 4'h0, 4'b0100, 4'b0100, 6'h23};
    tv[3]  = '{4'h0, 6'h05, 6'h1A, 6'h23, 6'h3C, 4'h0, 4'b1000, 4'b1000, 6'h3C};
    tv[4]  = '{4'h0, 6'h05, 6'h1A, 6'h23, 6'h3C, 4'h0, 4'b0001, 4'b0001, 6'h05};
    tv[5]  = '{4'b1001, 6'h05, 6'h36, 6'h09, 6'h3C, 4'b1000, 4'b0100, 4'b0001, 6'h09};
    tv[6]  = '{4'b1001, 6'h05, 6'h36, 6'h09, 6'h3C, 4'b1000, 4'b0100, 4'b0001, 6'h09};
    tv[7]  = '{4'b1001, 6'h05, 6'h36, 6'h09, 6'h3C, 4'b1000, 4'b0100, 4'b0001, 6'h09};
    tv[8]  = '{4'b1001, 6'h05, 6'h36, 6'h09, 6'h3C, 4'b0000, 4'b0010, 4'b1000, 6'h36};
    tv[9]  = '{4'b1001, 6'h05, 6'h36, 6'h09, 6'h3C, 4'b0000, 4'b0100, 4'b0001, 6'h09};
    tv[10] = '{4'h0, 6'h05, 6'h1A, 6'h23, 6'h3C, 4'hF, 4'b0000, 4'b0000, 6'h00};
    tv[11] = '{4'hF, 6'h05, 6'h1A, 6'h23, 6'h3C, 4'h0, 4'b0000, 4'b0000, 6'h00};

    reset = 1'b1; active_in = 1'b0; cnt_req = 1'b0; cnt_sel = 2'd0;
    bus.emp_I = 4'hF; bus.afull_O = 4'h0; set_words('0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    m_serve = 0; m_ptr = 0; m_cvalid = 0; m_cout = 0;
    for (int j = 0; j < 4; j++) m_cnt[j] = 0;

    // Reset held with live traffic present.
    active_in = 1'b1; bus.emp_I = 4'h0; set_words(6'h05, 6'h1A, 6'h23, 6'h3C);
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pop", 32'(bus.pop_I), 32'd0);
    chk("rst_push", 32'(bus.push_O), 32'd0);
    active_in = 1'b0; reset = 1'b0;
    tick();
    for (int j = 0; j < 4; j++) begin
      cnt_req = 1'b1; cnt_sel = 2'(j);
      tick();
      chk("rst_cnt_valid", 32'(cnt_valid), 32'd1);
      chk("rst_cnt_zero", 32'(cnt_out), 32'd0);
    end
    cnt_req = 1'b0;

    // I0 alone, three words to O2.
    active_in = 1'b1; bus.emp_I = 4'b1110; bus.data_I0 = 6'b10_0111;
    tick();
    chk("serve_entry", 32'(busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("i0_pop", 32'(bus.pop_I), 32'b0001);
      chk("i0_push", 32'(bus.push_O), 32'b0100);
      tick();
    end
    bus.emp_I = 4'hF; cnt_req = 1'b1; cnt_sel = 2'd2;
    tick();
    chk("i0_cnt2", 32'(cnt_out), 32'd3);
    cnt_req = 1'b0;

    // Vector table: rotation from pointer 0, then almost-full skipping.
    reset = 1'b1;
    tick();
    reset = 1'b0; active_in = 1'b1; bus.emp_I = 4'h0; bus.afull_O = 4'h0;
    set_words(6'h05, 6'h1A, 6'h23, 6'h3C);
    tick();
    for (int v = 0; v < 12; v++) begin
      bus.emp_I = tv[v].emp; bus.afull_O = tv[v].afull;
      set_words(tv[v].d0, tv[v].d1, tv[v].d2, tv[v].d3);
      #1;
      chk($sformatf("tv%0d_pop", v), 32'(bus.pop_I), 32'(tv[v].pop));
      chk($sformatf("tv%0d_push", v), 32'(bus.push_O), 32'(tv[v].push));
      chk($sformatf("tv%0d_data", v), 32'(bus.data_O), 32'(tv[v].dat));
      tick();
    end

    // active_in falls mid-stream: exactly the last SERVE cycle may transfer.
    reset = 1'b1;
    tick();
    reset = 1'b0; active_in = 1'b1; bus.emp_I = 4'h0; bus.afull_O = 4'h0;
    set_words(6'h05, 6'h1A, 6'h23, 6'h3C);
    tick();
    tick();
    active_in = 1'b0; xfers = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (bus.pop_I != 4'h0) xfers++;
      tick();
    end
    chk("drop_xfers", 32'(xfers), 32'd1);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_pop", 32'(bus.pop_I), 32'd0);

    // 256 pushes to O1, read coinciding with the final push.
    reset = 1'b1;
    tick();
    reset = 1'b0; active_in = 1'b1; bus.emp_I = 4'b1101; bus.data_I1 = 6'b01_0011;
    tick();
    for (int k = 0; k < 256; k++) begin
      if (k == 255) begin cnt_req = 1'b1; cnt_sel = 2'd1; end
      tick();
    end
    chk("wrap_pre_valid", 32'(cnt_valid), 32'd1);
    chk("wrap_pre_val", 32'(cnt_out), 32'd255);
    bus.emp_I = 4'hF;
    tick();
    chk("wrap_b2b_valid", 32'(cnt_valid), 32'd1);
    chk("wrap_zero", 32'(cnt_out), 32'd0);
    cnt_req = 1'b0;
    tick();
    chk("rd_pulse_end", 32'(cnt_valid), 32'd0);
    chk("rd_hold", 32'(cnt_out), 32'd0);

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      active_in = ($urandom_range(0, 9) != 0);
      bus.emp_I   = 4'($urandom);
      bus.afull_O = 4'($urandom & $urandom);
      set_words(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      cnt_req = 1'($urandom);
      cnt_sel = 2'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
